ps2_host_tx: RTL and testbench
==============================

PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 The block SHALL have one clock and one synchronous, active-high reset: clock port CLK100MHZ, reset port RST.
REQ-002 Parameter SHALL be INHIBIT_CYCLES, 12000, clock-low inhibit time (120 us at 100 MHz).
REQ-003 Parameter SHALL be REQ_CYCLES, 100, data-low setup time before releasing the clock.
REQ-004 Parameter SHALL be TIMEOUT_CYCLES, 2000000, maximum wait for any expected device edge (20 ms).
REQ-005 Parameter SHALL be FILTER_LEN, 8, number of consecutive equal samples needed to accept a line level.
REQ-006 Ports SHALL be as follows (name, direction, width, meaning):
- CLK100MHZ in 1: system clock.
- RST in 1: synchronous reset.
- TX_DATA in 8: command byte.
- TX_START in 1: 1-cycle request.
- PS2_CLK_IN in 1: raw PS/2 clock line.
- PS2_DATA_IN in 1: raw PS/2 data line.
- PS2_CLK_OE out 1: 1 pulls the clock line low, 0 releases it.
- PS2_DATA_OE out 1: 1 pulls the data line low, 0 releases it.
- BUSY out 1: a transfer is in progress; the keyboard receiver is gated with it.
- DONE out 1: 1-cycle pulse when the device acknowledges the byte.
- ERROR out 1: 1-cycle pulse on a NACK or a timeout.

Function
REQ-007 TX_START SHALL be accepted only in IDLE; on acceptance the block latches TX_DATA, computes parity = ~^TX_DATA (odd), and asserts BUSY on the next cycle.
REQ-008 TX_START while BUSY=1 SHALL be ignored with no queueing.
REQ-009 States SHALL be IDLE, INHIBIT, REQ, SHIFT, ACK, WAIT_IDLE.
REQ-010 INHIBIT: CLK_OE=1 and DATA_OE=0 for exactly INHIBIT_CYCLES cycles, then the block moves to REQ.
REQ-011 REQ: CLK_OE=1 and DATA_OE=1 (start bit) for REQ_CYCLES cycles, then the block moves to SHIFT with CLK_OE=0.
REQ-012 SHIFT: on each accepted falling edge of the filtered clock n=1..10, DATA_OE SHALL be driven to ~bit(n), where bits 1..8 are D0..D7 (LSB first), bit 9 is parity, and bit 10 is stop (1, so the line is released).
REQ-013 ACK: on the 11th accepted falling edge, the filtered data SHALL be sampled; 0 means ACK and 1 means NACK; either way the block goes to WAIT_IDLE.
REQ-014 WAIT_IDLE: the block waits until the filtered clock and data are both 1, then enters IDLE.
- In the same cycle it pulses DONE (ACK) or ERROR (NACK) and deasserts BUSY.
REQ-015 Timeout: in SHIFT, ACK and WAIT_IDLE, a counter SHALL reload on every accepted edge. When it reaches TIMEOUT_CYCLES:
- both OE outputs drop to 0;
- ERROR pulses;
- the block enters IDLE.
REQ-016 Line filter: each raw input SHALL pass a 2-FF synchronizer and then a FILTER_LEN-sample glitch filter; a falling edge is the 1->0 transition of the filtered clock, and the first edge is accepted no earlier than the cycle after REQ exits.
REQ-017 Latency from the accepted falling edge to the DATA_OE update SHALL be 1 cycle; the filter delay is FILTER_LEN+2 cycles after the raw edge.
REQ-018 DONE and ERROR SHALL never both be asserted, and each SHALL be exactly one cycle wide.
REQ-019 Counters SHALL be sized with $clog2 of their parameter and SHALL saturate, never wrap.

Reset
REQ-020 RST SHALL take priority over all other inputs, including TX_START in the same cycle.
REQ-021 On RST: state IDLE, PS2_CLK_OE=0, PS2_DATA_OE=0, BUSY=0, DONE=0, ERROR=0, all counters 0, filters preset to 1 (idle-high lines).
REQ-022 RST during a transfer SHALL release both lines on the next edge and SHALL produce no DONE or ERROR pulse.

Structure
REQ-023 Package pong_ps2_pkg SHALL hold the state enum typedef and the default timing constants, shared with the keyboard receiver.
REQ-024 Sub-module ps2_line_filter SHALL provide the synchronizer, the glitch filter and the falling-edge strobe, instantiated twice (clock, data).
REQ-025 Tristate conversion of the OE outputs SHALL be done in the top level, not in this block.

Verification (INHIBIT_CYCLES=50, REQ_CYCLES=5, TIMEOUT_CYCLES=2000 in the bench)
REQ-026 TX_DATA=0xED, device model clocks 11 edges and drives ACK low -> DATA_OE bit sequence 1,0,1,1,0,1,1,1, parity 1 (line released), stop released, DONE pulse, BUSY low.
REQ-027 TX_DATA=0x00 with the device returning NACK (data high at edge 11) -> parity bit driven 1 (released), ERROR pulse, no DONE.
REQ-028 The device never clocks after REQ -> ERROR at exactly 2000 cycles after SHIFT entry, both OE outputs 0.
REQ-029 A second TX_START 10 cycles after the first -> ignored, exactly one transfer carrying the first byte.
REQ-030 RST at edge 5 of SHIFT -> both OE outputs 0 and BUSY 0 next cycle, no pulses; a new TX_START afterwards completes normally.
REQ-031 A 3-cycle glitch low on PS2_CLK_IN in SHIFT -> no bit advance; the state and DATA_OE are unchanged.

Source files
------------

// File: rtl/pong_ps2_pkg.sv
// pong_ps2_pkg: PS/2 host transmitter state encoding and default line timing,
// shared with the keyboard receiver.
package pong_ps2_pkg;
    typedef enum logic [2:0] {IDLE, INHIBIT, REQ, SHIFT, ACK, WAIT_IDLE} ps2_state_e;
    localparam int PS2_INHIBIT_CYCLES = 12000;
    localparam int PS2_REQ_CYCLES     = 100;
    localparam int PS2_TIMEOUT_CYCLES = 2000000;
    localparam int PS2_FILTER_LEN     = 8;
endpackage

// File: rtl/ps2_line_filter.sv
// ps2_line_filter: 2-FF synchronizer plus N-sample glitch filter for one PS/2 line,
// with a registered strobe on each filtered 1->0 transition.
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic line_i,
    output logic level_o,
    output logic fall_o
);
    localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    logic [1:0]    sync_q;
    logic [FW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d, fall_q;
    // The level flips only after FILTER_LEN consecutive samples disagree with it.
    always_comb begin
        cnt_d   = (sync_q[1] == level_q || cnt_q == FW'(FILTER_LEN - 1)) ? '0 : cnt_q + 1'b1;
        level_d = (sync_q[1] != level_q && cnt_q == FW'(FILTER_LEN - 1)) ? sync_q[1] : level_q;
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q  <= 2'b11;
            cnt_q   <= '0;
            level_q <= 1'b1;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], line_i};
            cnt_q   <= cnt_d;
            level_q <= level_d;
            fall_q  <= level_q & ~level_d;
        end
    end
    assign level_o = level_q;
    assign fall_o  = fall_q;
endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: sends one command byte host-to-device over PS/2 (inhibit, request,
// shift 8 data + parity + stop, sample ACK), with a per-edge timeout.
module ps2_host_tx
    import pong_ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = PS2_INHIBIT_CYCLES,
    parameter int REQ_CYCLES     = PS2_REQ_CYCLES,
    parameter int TIMEOUT_CYCLES = PS2_TIMEOUT_CYCLES,
    parameter int FILTER_LEN     = PS2_FILTER_LEN
) (
    input  logic       CLK100MHZ,
    input  logic       RST,
    input  logic [7:0] TX_DATA,
    input  logic       TX_START,
    input  logic       PS2_CLK_IN,
    input  logic       PS2_DATA_IN,
    output logic       PS2_CLK_OE,
    output logic       PS2_DATA_OE,
    output logic       BUSY,
    output logic       DONE,
    output logic       ERROR
);
    localparam int MAX_IR = (INHIBIT_CYCLES > REQ_CYCLES) ? INHIBIT_CYCLES : REQ_CYCLES;
    localparam int MAXC   = (TIMEOUT_CYCLES > MAX_IR) ? TIMEOUT_CYCLES : MAX_IR;
    localparam int CW     = $clog2(MAXC + 1);
    ps2_state_e    state_q, state_d;
    logic [CW-1:0] tmr_q, tmr_d;
    logic [3:0]    bit_q, bit_d;
    logic [9:0]    sh_q, sh_d;
    logic          clk_oe_q, clk_oe_d, data_oe_q, data_oe_d;
    logic          ack_q, ack_d, done_q, done_d, err_q, err_d;
    logic          clk_f, clk_fall, data_f, data_fall_unused;
    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
        .clk_i(CLK100MHZ), .rst_i(RST), .line_i(PS2_CLK_IN), .level_o(clk_f), .fall_o(clk_fall)
    );
    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filt (
        .clk_i(CLK100MHZ), .rst_i(RST), .line_i(PS2_DATA_IN), .level_o(data_f), .fall_o(data_fall_unused)
    );
    always_comb begin
        state_d   = state_q;
        tmr_d     = tmr_q;
        bit_d     = bit_q;
        sh_d      = sh_q;
        clk_oe_d  = clk_oe_q;
        data_oe_d = data_oe_q;
        ack_d     = ack_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            IDLE: if (TX_START) begin
                state_d  = INHIBIT;
                sh_d     = {1'b1, ~^TX_DATA, TX_DATA};
                clk_oe_d = 1'b1;
                tmr_d    = '0;
            end
            INHIBIT: if (tmr_q == CW'(INHIBIT_CYCLES - 1)) begin
                state_d   = REQ;
                tmr_d     = '0;
                data_oe_d = 1'b1;
            end else tmr_d = tmr_q + 1'b1;
            REQ: if (tmr_q == CW'(REQ_CYCLES - 1)) begin
                state_d  = SHIFT;
                tmr_d    = '0;
                bit_d    = '0;
                clk_oe_d = 1'b0;
            end else tmr_d = tmr_q + 1'b1;
            default: begin
                // SHIFT, ACK and WAIT_IDLE share the edge timeout
                tmr_d = clk_fall ? '0 : (tmr_q == CW'(MAXC) ? tmr_q : tmr_q + 1'b1);
                if (state_q == SHIFT && clk_fall) begin
                    data_oe_d = ~sh_q[bit_q];
                    bit_d     = bit_q + 1'b1;
                    state_d   = (bit_q == 4'd9) ? ACK : SHIFT;
                end
                if (state_q == ACK && clk_fall) begin
                    ack_d   = ~data_f;
                    state_d = WAIT_IDLE;
                end
                if (state_q == WAIT_IDLE && clk_f && data_f) begin
                    state_d = IDLE;
                    done_d  = ack_q;
                    err_d   = ~ack_q;
                end
                if (!clk_fall && tmr_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    state_d   = IDLE;
                    clk_oe_d  = 1'b0;
                    data_oe_d = 1'b0;
                    done_d    = 1'b0;
                    err_d     = 1'b1;
                end
            end
        endcase
    end
    always_ff @(posedge CLK100MHZ) begin
        if (RST) begin
            state_q   <= IDLE;
            tmr_q     <= '0;
            bit_q     <= '0;
            sh_q      <= '0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            ack_q     <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            tmr_q     <= tmr_d;
            bit_q     <= bit_d;
            sh_q      <= sh_d;
            clk_oe_q  <= clk_oe_d;
            data_oe_q <= data_oe_d;
            ack_q     <= ack_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end
    assign PS2_CLK_OE  = clk_oe_q;
    assign PS2_DATA_OE = data_oe_q;
    assign BUSY        = (state_q != IDLE);
    assign DONE        = done_q;
    assign ERROR       = err_q;
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: drives ps2_host_tx against an open-drain PS/2 device model and
// checks the observed frame, timing and pulses against values computed from the byte.
module tb_ps2_host_tx;
    localparam int INH  = 50;
    localparam int RQ   = 5;
    localparam int TO   = 2000;
    localparam int HALF = 20;
    logic       clk = 1'b0, rst = 1'b1, tx_start = 1'b0;
    logic [7:0] tx_data = '0;
    logic       dev_clk = 1'b1, dev_data = 1'b1, glitch = 1'b0;
    logic       ps2_clk_in, ps2_data_in, clk_oe, data_oe, busy, done, error;
    int         n_chk = 0, n_fail = 0;
    int         done_cnt = 0, err_cnt = 0, both_cnt = 0, wide_cnt = 0;
    logic       pd = 1'b0, pe = 1'b0;
    always #5 clk = ~clk;
    assign ps2_clk_in  = ~clk_oe & dev_clk & ~glitch;
    assign ps2_data_in = ~data_oe & dev_data;
    ps2_host_tx #(.INHIBIT_CYCLES(INH), .REQ_CYCLES(RQ), .TIMEOUT_CYCLES(TO)) dut (
        .CLK100MHZ(clk), .RST(rst), .TX_DATA(tx_data), .TX_START(tx_start),
        .PS2_CLK_IN(ps2_clk_in), .PS2_DATA_IN(ps2_data_in),
        .PS2_CLK_OE(clk_oe), .PS2_DATA_OE(data_oe),
        .BUSY(busy), .DONE(done), .ERROR(error)
    );
    always @(posedge clk) begin
        #1;
        if (done === 1'b1) done_cnt++;
        if (error === 1'b1) err_cnt++;
        if (done === 1'b1 && error === 1'b1) both_cnt++;
        if ((done === 1'b1 && pd) || (error === 1'b1 && pe)) wide_cnt++;
        pd = (done === 1'b1);
        pe = (error === 1'b1);
    end
    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
        $fatal(1, "watchdog");
    end
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask
    // Request a transfer and measure the inhibit and request phases.
    task automatic begin_tx(input logic [7:0] b, input int dup);
        int c;
        tx_data = b;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        tx_data = 8'($urandom);
        chk("busy_after_start", 32'(busy), 1);
        c = 0;
        while (clk_oe === 1'b1 && data_oe === 1'b0 && c < 1000) begin
            c++;
            if (c == dup) begin
                tx_data = ~b;
                tx_start = 1'b1;
            end
            @(negedge clk);
            tx_start = 1'b0;
        end
        chk("inhibit_len", c, INH);
        c = 0;
        while (clk_oe === 1'b1 && data_oe === 1'b1 && c < 1000) begin
            c++;
            @(negedge clk);
        end
        chk("req_len", c, RQ);
        chk("start_bit_oe", {30'd0, clk_oe, data_oe}, 32'b01);
    endtask
    task automatic xfer(input logic [7:0] b, input bit ack, input int dup, input int abort_at, input bit glitch_en);
        int d0, e0, c;
        logic [9:0] got, exp;
        logic hold;
        d0 = done_cnt;
        e0 = err_cnt;
        got = '0;
        exp = {1'b1, ($countones(b) % 2 == 0) ? 1'b1 : 1'b0, b};
        begin_tx(b, dup);
        cyc(30);
        for (int i = 1; i <= 11; i++) begin
            if (i == 11) begin
                dev_data = ~ack;
                cyc(5);
            end
            dev_clk = 1'b0;
            cyc(HALF);
            if (i <= 10) got[i-1] = ps2_data_in;
            if (i == abort_at) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                chk("abort_oe", {30'd0, clk_oe, data_oe}, 0);
                chk("abort_busy", 32'(busy), 0);
                dev_clk = 1'b1;
                dev_data = 1'b1;
                cyc(50);
                chk("abort_no_pulse", (done_cnt - d0) + (err_cnt - e0), 0);
                return;
            end
            dev_clk = 1'b1;
            if (glitch_en && i == 3) begin
                cyc(5);
                hold = data_oe;
                glitch = 1'b1;
                cyc(3);
                glitch = 1'b0;
                cyc(12);
                chk("glitch_data_oe", 32'(data_oe), 32'(hold));
            end else cyc(HALF);
            if (i == 11) dev_data = 1'b1;
        end
        c = 0;
        while (done_cnt == d0 && err_cnt == e0 && c < 500) begin
            c++;
            cyc(1);
        end
        cyc(2);
        chk("frame_bits", 32'(got), 32'(exp));
        chk("done_count", done_cnt - d0, ack ? 1 : 0);
        chk("error_count", err_cnt - e0, ack ? 0 : 1);
        chk("busy_end", 32'(busy), 0);
        chk("oe_end", {30'd0, clk_oe, data_oe}, 0);
    endtask
    initial begin
        int k, e0, d0;
        logic [7:0] rb;
        bit ra;
        tx_start = 1'b1;
        cyc(3);
        chk("rst_clk_oe", 32'(clk_oe), 0);
        chk("rst_data_oe", 32'(data_oe), 0);
        chk("rst_busy_over_start", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_error", 32'(error), 0);
        tx_start = 1'b0;
        rst = 1'b0;
        cyc(5);
        xfer(8'hED, 1'b1, 0, 0, 1'b0);
        xfer(8'h00, 1'b0, 0, 0, 1'b0);
        d0 = done_cnt;
        e0 = err_cnt;
        begin_tx(8'h5A, 0);
        k = 0;
        while (error !== 1'b1 && k < 3000) begin
            @(negedge clk);
            k++;
        end
        chk("timeout_cycles", k, TO);
        chk("timeout_oe", {30'd0, clk_oe, data_oe}, 0);
        @(negedge clk);
        chk("timeout_busy", 32'(busy), 0);
        chk("timeout_err_count", err_cnt - e0, 1);
        chk("timeout_done_count", done_cnt - d0, 0);
        xfer(8'h3C, 1'b1, 10, 0, 1'b0);
        cyc(100);
        chk("dup_no_second_tx", {30'd0, clk_oe, busy}, 0);
        xfer(8'h96, 1'b1, 0, 5, 1'b0);
        xfer(8'hF4, 1'b1, 0, 0, 1'b0);
        xfer(8'hA5, 1'b1, 0, 0, 1'b1);
        for (int n = 0; n < 4; n++) begin
            rb = 8'($urandom);
            ra = 1'($urandom);
            xfer(rb, ra, 0, 0, 1'b0);
        end
        chk("never_both_pulses", both_cnt, 0);
        chk("pulse_width_one", wide_cnt, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
